aurora_link_sequencer: RTL
==========================

# aurora_link_sequencer

Bring-up and recovery controller for the 2-lane Aurora QSFP link on the U50. It drives the Aurora core's `pma_init` and `reset_pb` in the required order and watches `channel_up`, `lane_up` and `hard_err`. When a bring-up attempt times out or an established link drops, it retries with bounded attempts. It sits beside the Aurora core and the GT serial pin interface, in the `init_clk` domain.

## Interface

- `LANES`, 2 — Aurora lane count (width of `lane_up`).
- `PMA_INIT_CYCLES`, 128 — cycles `pma_init` is held high per attempt; minimum 2.
- `PB_HOLD_CYCLES`, 64 — cycles `reset_pb` stays high after `pma_init` falls; minimum 2.
- `UP_TIMEOUT`, 2**20 — cycles allowed for channel-up after `reset_pb` falls; minimum 2.
- `RETRY_MAX`, 4 — consecutive failed attempts before FAIL; range 1..255.

Ports (name, direction, width, meaning):

- `init_clk` in 1 — free-running init clock; the only clock.
- `sys_reset` in 1 — synchronous, active-high reset.
- `enable` in 1 — level input; 1 permits link bring-up.
- `restart` in 1 — single-cycle pulse forcing a fresh attempt.
- `channel_up` in 1 — from the Aurora core, asynchronous to `init_clk`.
- `lane_up` in LANES — from the Aurora core, asynchronous.
- `hard_err` in 1 — from the Aurora core, asynchronous.
- `pma_init` out 1 — to the Aurora core.
- `reset_pb` out 1 — to the Aurora core.
- `link_up` out 1 — high only in UP.
- `link_fail` out 1 — high only in FAIL.
- `state` out 3 — current state code.
- `retry_cnt` out 8 — consecutive failed attempts.
- `drop_cnt` out 16 — saturating count of UP→retry events.

## Operation

- `channel_up`, `lane_up` and `hard_err` each pass through a 2-FF synchronizer. Define `up_ok_s = channel_up_s & (&lane_up_s)`.
- States and codes: IDLE=0, ASSERT=1, HOLD=2, WAIT_UP=3, UP=4, FAIL=5.
- Outputs per state:
  - `pma_init`=1 in IDLE, ASSERT and FAIL; 0 otherwise.
  - `reset_pb`=1 in IDLE, ASSERT, HOLD and FAIL; 0 in WAIT_UP and UP.
- Transition priority: `sys_reset` > `!enable` (→IDLE) > `restart` (→ASSERT; clears `retry_cnt`; not taken from IDLE) > per-state rules below.
- Per-state rules:
  - IDLE: `enable`=1 → ASSERT.
  - ASSERT: after PMA_INIT_CYCLES cycles in the state → HOLD.
  - HOLD: after PB_HOLD_CYCLES cycles → WAIT_UP.
  - WAIT_UP: `up_ok_s` → UP and clear `retry_cnt`. Otherwise, at the UP_TIMEOUT-th cycle → failure.
  - UP: `!up_ok_s` or `hard_err_s` → failure; `drop_cnt` +1, saturating at 16'hFFFF.
  - FAIL: stays until `restart` or `!enable`.
- Failure handling: `retry_cnt` increments. If the new value equals RETRY_MAX → FAIL; otherwise → ASSERT.
- Single phase counter:
  - Cleared on every state entry.
  - Width is `$clog2` of the largest of the three cycle parameters, plus 1.
  - Counts cycles spent in the current state.
- If `up_ok_s` and the timeout fall on the same WAIT_UP cycle, `up_ok_s` wins.

## Timing

- Reset values: `state`=IDLE, `pma_init`=1, `reset_pb`=1, `link_up`=0, `link_fail`=0, `retry_cnt`=0, `drop_cnt`=0, synchronizer flops=0, phase counter=0.
- All outputs are registered and change on the same edge as `state`.
- Input-to-decision latency is 2 cycles (synchronizer). `link_up` rises 3 cycles after `channel_up` rises, given `lane_up` is already high.
- Phase durations are exact: `pma_init` high for PMA_INIT_CYCLES cycles in ASSERT; `reset_pb` low-going edge exactly PB_HOLD_CYCLES cycles after `pma_init` falls.
- Retry re-entry takes 1 cycle: a failure in WAIT_UP or UP makes ASSERT visible on the next edge.
- `sys_reset` mid-attempt returns to IDLE on the next edge; counters are cleared and outputs take their reset values.
- `restart` in IDLE is ignored.

## Structure

- Shared package/include `aurora_seq_pkg`: state code localparams (3-bit) and default parameter constants.
- Sub-module `sync_2ff` (parameterized width) is instantiated once for `{hard_err, lane_up, channel_up}`.
- The FSM, phase counter and stat counters live in the top module.

## Test plan

All scenarios use PMA_INIT_CYCLES=8, PB_HOLD_CYCLES=4, UP_TIMEOUT=32, RETRY_MAX=3.

- **Clean bring-up:**
  - Stimulus: `enable`=1 from reset; `lane_up`=2'b11 and `channel_up`=1 raised 10 cycles into WAIT_UP.
  - Required: `pma_init` high exactly 8 cycles; `reset_pb` falls 4 cycles later; `link_up`=1 exactly 3 cycles after `channel_up` rises; `retry_cnt`=0.
- **Timeout exhaustion:**
  - Stimulus: `channel_up` held at 0.
  - Required: three 32-cycle WAIT_UP windows; `retry_cnt` reads 1, 2, 3; `link_fail`=1 with `state`=5 after the third; `pma_init`=1 and `reset_pb`=1 held in FAIL.
- **Link drop:**
  - Stimulus: in UP, deassert `lane_up[1]` for 5 cycles.
  - Required: ASSERT 3 cycles after the deassert edge; `drop_cnt`=1; `retry_cnt`=1.
- **hard_err while up:**
  - Stimulus: in UP, `hard_err` pulse of 3 cycles.
  - Required: ASSERT entered; `drop_cnt` +1; `link_up` falls on the same edge.
- **Restart and enable:**
  - Stimulus: `restart` in FAIL; then `enable`=0 during HOLD.
  - Required: `restart` → ASSERT with `retry_cnt`=0 and `link_fail`=0; `enable`=0 → IDLE on the next edge; `restart` in IDLE leaves `state`=0.
- **Simultaneous events and reset:**
  - Stimulus: `up_ok_s` asserted on the 32nd WAIT_UP cycle; separately, `sys_reset` during WAIT_UP.
  - Required: the first → UP, not a retry; the second → all outputs at their reset values on the next edge.

Source files
------------

// File: rtl/aurora_seq_pkg.sv
// Shared definitions for the Aurora link bring-up sequencer.
// Contents: 3-bit state codes, the state enum built on those codes,
// default parameter constants and a small max helper used to size the
// phase counter.
package aurora_seq_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ASSERT  = 3'd1;
    localparam logic [2:0] ST_HOLD    = 3'd2;
    localparam logic [2:0] ST_WAIT_UP = 3'd3;
    localparam logic [2:0] ST_UP      = 3'd4;
    localparam logic [2:0] ST_FAIL    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_ASSERT  = ST_ASSERT,
        S_HOLD    = ST_HOLD,
        S_WAIT_UP = ST_WAIT_UP,
        S_UP      = ST_UP,
        S_FAIL    = ST_FAIL
    } seq_state_e;

    localparam int DEF_LANES           = 2;
    localparam int DEF_PMA_INIT_CYCLES = 128;
    localparam int DEF_PB_HOLD_CYCLES  = 64;
    localparam int DEF_UP_TIMEOUT      = 1 << 20;
    localparam int DEF_RETRY_MAX       = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bundle of slow, independently changing level
// signals entering the init_clk domain.
// Ports: clk (destination clock), rst (sync active-high, clears both
// stages), d (asynchronous inputs), q (synchronized outputs).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aurora_link_sequencer.sv
// Bring-up and recovery controller for a multi-lane Aurora link.
// Sequences pma_init and reset_pb, watches channel_up/lane_up/hard_err
// (synchronized), and retries failed or dropped links up to RETRY_MAX
// consecutive attempts before parking in FAIL.
// Ports:
//   init_clk, sys_reset        - clock and sync active-high reset
//   enable, restart            - permit bring-up level / fresh-attempt pulse
//   channel_up, lane_up,
//   hard_err                   - asynchronous status from the Aurora core
//   pma_init, reset_pb         - reset controls to the Aurora core
//   link_up, link_fail, state  - status (state code 0..5)
//   retry_cnt, drop_cnt        - consecutive failures / saturating drop count
module aurora_link_sequencer
    import aurora_seq_pkg::*;
#(
    parameter int LANES           = DEF_LANES,
    parameter int PMA_INIT_CYCLES = DEF_PMA_INIT_CYCLES,
    parameter int PB_HOLD_CYCLES  = DEF_PB_HOLD_CYCLES,
    parameter int UP_TIMEOUT      = DEF_UP_TIMEOUT,
    parameter int RETRY_MAX       = DEF_RETRY_MAX
) (
    input  logic             init_clk,
    input  logic             sys_reset,
    input  logic             enable,
    input  logic             restart,
    input  logic             channel_up,
    input  logic [LANES-1:0] lane_up,
    input  logic             hard_err,
    output logic             pma_init,
    output logic             reset_pb,
    output logic             link_up,
    output logic             link_fail,
    output logic [2:0]       state,
    output logic [7:0]       retry_cnt,
    output logic [15:0]      drop_cnt
);

    localparam int PHASE_W = $clog2(max3(PMA_INIT_CYCLES, PB_HOLD_CYCLES, UP_TIMEOUT)) + 1;

    logic [LANES+1:0]   sync_q;
    logic               channel_up_s;
    logic [LANES-1:0]   lane_up_s;
    logic               hard_err_s;
    logic               up_ok_s;

    seq_state_e         cur;
    seq_state_e         nxt;
    logic [PHASE_W-1:0] phase_cnt;
    logic               enter;
    logic               fail_evt;
    logic               retry_clr;
    logic               drop_inc;
    logic [7:0]         retry_inc;

    sync_2ff #(.WIDTH(LANES + 2)) u_sync (
        .clk (init_clk),
        .rst (sys_reset),
        .d   ({hard_err, lane_up, channel_up}),
        .q   (sync_q)
    );

    assign channel_up_s = sync_q[0];
    assign lane_up_s    = sync_q[LANES:1];
    assign hard_err_s   = sync_q[LANES+1];
    assign up_ok_s      = channel_up_s & (&lane_up_s);
    assign retry_inc    = retry_cnt + 8'd1;
    assign state        = cur;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Only the timed phases need the counter; elsewhere it holds.
    function automatic logic is_timed(input seq_state_e s);
        return (s == S_ASSERT) || (s == S_HOLD) || (s == S_WAIT_UP);
    endfunction

    // enter marks every taken transition, including restart re-entering
    // ASSERT, so the phase counter restarts from zero on each entry.
    always_comb begin
        nxt       = cur;
        enter     = 1'b0;
        fail_evt  = 1'b0;
        retry_clr = 1'b0;
        drop_inc  = 1'b0;
        if (!enable) begin
            nxt   = S_IDLE;
            enter = 1'b1;
        end else if (restart && (cur != S_IDLE)) begin
            nxt       = S_ASSERT;
            enter     = 1'b1;
            retry_clr = 1'b1;
        end else begin
            case (cur)
                S_IDLE: begin
                    nxt   = S_ASSERT;
                    enter = 1'b1;
                end
                S_ASSERT: begin
                    if (phase_cnt == PHASE_W'(PMA_INIT_CYCLES - 1)) begin
                        nxt   = S_HOLD;
                        enter = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (phase_cnt == PHASE_W'(PB_HOLD_CYCLES - 1)) begin
                        nxt   = S_WAIT_UP;
                        enter = 1'b1;
                    end
                end
                S_WAIT_UP: begin
                    // A link coming up on the timeout cycle still counts as up.
                    if (up_ok_s) begin
                        nxt       = S_UP;
                        enter     = 1'b1;
                        retry_clr = 1'b1;
                    end else if (phase_cnt == PHASE_W'(UP_TIMEOUT - 1)) begin
                        fail_evt = 1'b1;
                    end
                end
                S_UP: begin
                    if (!up_ok_s || hard_err_s) begin
                        fail_evt = 1'b1;
                        drop_inc = 1'b1;
                    end
                end
                default: ;
            endcase
            if (fail_evt) begin
                enter = 1'b1;
                nxt   = (retry_inc == 8'(RETRY_MAX)) ? S_FAIL : S_ASSERT;
            end
        end
    end

    // Outputs decode the next state so they change on the same edge as state.
    always_ff @(posedge init_clk) begin
        if (sys_reset) begin
            cur       <= S_IDLE;
            phase_cnt <= '0;
            retry_cnt <= 8'd0;
            drop_cnt  <= 16'd0;
            pma_init  <= 1'b1;
            reset_pb  <= 1'b1;
            link_up   <= 1'b0;
            link_fail <= 1'b0;
        end else begin
            cur       <= nxt;
            phase_cnt <= enter ? '0 : (is_timed(cur) ? phase_cnt + 1'b1 : phase_cnt);
            retry_cnt <= retry_clr ? 8'd0 : (fail_evt ? retry_inc : retry_cnt);
            drop_cnt  <= drop_inc ? sat_inc16(drop_cnt) : drop_cnt;
            pma_init  <= (nxt == S_IDLE) || (nxt == S_ASSERT) || (nxt == S_FAIL);
            reset_pb  <= (nxt == S_IDLE) || (nxt == S_ASSERT) || (nxt == S_HOLD) || (nxt == S_FAIL);
            link_up   <= (nxt == S_UP);
            link_fail <= (nxt == S_FAIL);
        end
    end

endmodule
